// File: rtl/ex_md_sequencer_pkg.sv
// Shared encodings and result post-processing for the RV32M multiply/divide sequencer.
// Holds the funct3 codes, the FSM state type and the sign-fixup/word-select helper.
package ex_md_sequencer_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  // acc holds {hi, lo} of a product, or {remainder, quotient} of a divide.
  function automatic logic [31:0] md_finalize(input logic [2:0]  funct3,
                                              input logic        neg,
                                              input logic [63:0] acc);
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    prod = neg ? -acc : acc;
    quo  = neg ? -acc[31:0] : acc[31:0];
    rem  = neg ? -acc[63:32] : acc[63:32];
    case (funct3)
      MD_MUL:                      return prod[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: return prod[63:32];
      MD_DIV, MD_DIVU:             return quo;
      default:                     return rem;
    endcase
  endfunction

endpackage

// File: rtl/md_iter_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
// acc_i is {product_hi, multiplier} for multiply and {remainder, dividend/quotient} for divide.
module md_iter_step (
  input  logic        is_div,
  input  logic [63:0] acc_i,
  input  logic [31:0] operand_i,
  output logic [63:0] acc_o
);

  logic [32:0] sum;
  logic [32:0] part_rem;
  logic [31:0] diff;
  logic        fits;

  always_comb begin
    sum      = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, operand_i} : 33'd0);
    // The 33-bit partial remainder catches the bit shifted out of a large remainder.
    part_rem = acc_i[63:31];
    fits     = part_rem >= {1'b0, operand_i};
    diff     = part_rem[31:0] - operand_i;
    if (is_div) begin
      acc_o = fits ? {diff, acc_i[30:0], 1'b1} : {acc_i[62:0], 1'b0};
    end else begin
      acc_o = {sum, acc_i[31:1]};
    end
  end

endmodule

// File: rtl/ex_md_sequencer.sv
// Iterative RV32M multiply/divide sequencer beside the execute ALU; stalls the pipeline while busy.
// Optional single-cycle multiply when MD_FAST_MUL_EN is defined.
import ex_md_sequencer_pkg::*;

module ex_md_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            de2ex_MD_OP_ffout,
  input  logic            de2ex_inst_valid_ffout,
  input  logic [2:0]      de2ex_md_funct3_ffout,
  input  logic [XLEN-1:0] de2ex_rd_oprand1_ffout,
  input  logic [XLEN-1:0] de2ex_rd_oprand2_ffout,
  input  logic [4:0]      de2ex_wr_regindex_ffout,
  input  logic            ex_flush,
  output logic            md2ex_stall,
  output logic            md2ex_valid,
  output logic [XLEN-1:0] md2ex_result,
  output logic [4:0]      md2ex_wr_regindex,
  output logic            md2ex_busy
);

  md_state_e   state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  wr_regindex_q, wr_regindex_d;

  logic [2:0]  f_in;
  logic [31:0] op1, op2, mag1, mag2;
  logic        start, sgn1, sgn2, div_zero, div_ovf;
  logic [63:0] step_acc;

  assign f_in  = de2ex_md_funct3_ffout;
  assign op1   = de2ex_rd_oprand1_ffout;
  assign op2   = de2ex_rd_oprand2_ffout;
  assign start = de2ex_MD_OP_ffout & de2ex_inst_valid_ffout & ~ex_flush;

  assign sgn1 = op1[31] & (f_in == MD_MULH || f_in == MD_MULHSU || f_in == MD_DIV || f_in == MD_REM);
  assign sgn2 = op2[31] & (f_in == MD_MULH || f_in == MD_DIV || f_in == MD_REM);
  assign mag1 = sgn1 ? -op1 : op1;
  assign mag2 = sgn2 ? -op2 : op2;

  assign div_zero = f_in[2] & (op2 == 32'd0);
  assign div_ovf  = f_in[2] & ~f_in[0] & (op1 == 32'h8000_0000) & (op2 == 32'hFFFF_FFFF);

`ifdef MD_FAST_MUL_EN
  logic [63:0] fast_prod;
  assign fast_prod = 64'($signed({sgn1, op1}) * $signed({sgn2, op2}));
`endif

  md_iter_step u_step (
    .is_div    (funct3_q[2]),
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .acc_o     (step_acc)
  );

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch can leave a latch behind.
    state_d       = state_q;
    funct3_d      = funct3_q;
    rd_d          = rd_q;
    cnt_d         = cnt_q;
    neg_d         = neg_q;
    acc_d         = acc_q;
    opnd_d        = opnd_q;
    result_d      = result_q;
    wr_regindex_d = wr_regindex_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          funct3_d = f_in;
          rd_d     = de2ex_wr_regindex_ffout;
          cnt_d    = 5'd31;
          neg_d    = (f_in == MD_REM) ? sgn1 : (sgn1 ^ sgn2);
          acc_d    = {32'd0, mag1};
          opnd_d   = mag2;
          if (div_zero) begin
            result_d      = f_in[1] ? op1 : 32'hFFFF_FFFF;
            wr_regindex_d = de2ex_wr_regindex_ffout;
            state_d       = MD_DONE;
          end else if (div_ovf) begin
            result_d      = f_in[1] ? 32'd0 : 32'h8000_0000;
            wr_regindex_d = de2ex_wr_regindex_ffout;
            state_d       = MD_DONE;
`ifdef MD_FAST_MUL_EN
          end else if (!f_in[2]) begin
            result_d      = md_finalize(f_in, 1'b0, fast_prod);
            wr_regindex_d = de2ex_wr_regindex_ffout;
            state_d       = MD_DONE;
`endif
          end else begin
            state_d = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        if (ex_flush) begin
          state_d = MD_IDLE;
        end else begin
          acc_d = step_acc;
          // Result is fixed up on the way into DONE so it is a clean register output.
          if (cnt_q == 5'd0) begin
            result_d      = md_finalize(funct3_q, neg_q, step_acc);
            wr_regindex_d = rd_q;
            state_d       = MD_DONE;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= MD_IDLE;
      funct3_q      <= 3'd0;
      rd_q          <= 5'd0;
      cnt_q         <= 5'd0;
      neg_q         <= 1'b0;
      acc_q         <= 64'd0;
      opnd_q        <= 32'd0;
      result_q      <= 32'd0;
      wr_regindex_q <= 5'd0;
    end else begin
      state_q       <= state_d;
      funct3_q      <= funct3_d;
      rd_q          <= rd_d;
      cnt_q         <= cnt_d;
      neg_q         <= neg_d;
      acc_q         <= acc_d;
      opnd_q        <= opnd_d;
      result_q      <= result_d;
      wr_regindex_q <= wr_regindex_d;
    end
  end

  assign md2ex_stall       = ((state_q == MD_IDLE) & start) | (state_q == MD_CALC);
  assign md2ex_valid       = (state_q == MD_DONE) & ~ex_flush;
  assign md2ex_busy        = (state_q != MD_IDLE);
  assign md2ex_result      = result_q;
  assign md2ex_wr_regindex = wr_regindex_q;

endmodule

// File: tb/tb_ex_md_sequencer.sv
// Scoreboard bench for ex_md_sequencer: expected beats are queued at issue and checked on md2ex_valid.
// Honours MD_FAST_MUL_EN for multiply latency.
module tb_ex_md_sequencer;

`ifdef MD_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        md_op = 1'b0;
  logic        inst_valid = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] opa = 32'd0;
  logic [31:0] opb = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        flush = 1'b0;
  logic        md2ex_stall, md2ex_valid, md2ex_busy;
  logic [31:0] md2ex_result;
  logic [4:0]  md2ex_wr_regindex;

  ex_md_sequencer dut (
    .clk                     (clk),
    .rst                     (rst),
    .de2ex_MD_OP_ffout       (md_op),
    .de2ex_inst_valid_ffout  (inst_valid),
    .de2ex_md_funct3_ffout   (funct3),
    .de2ex_rd_oprand1_ffout  (opa),
    .de2ex_rd_oprand2_ffout  (opb),
    .de2ex_wr_regindex_ffout (rd_in),
    .ex_flush                (flush),
    .md2ex_stall             (md2ex_stall),
    .md2ex_valid             (md2ex_valid),
    .md2ex_result            (md2ex_result),
    .md2ex_wr_regindex       (md2ex_wr_regindex),
    .md2ex_busy              (md2ex_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] md_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'd0, b};
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int op_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    if (!f[2]) return MUL_LAT;
    return 33;
  endfunction

  // Every result beat must match the oldest queued expectation, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && md2ex_valid === 1'b1) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: valid=1 res=%h at cycle %0d, required no beat", md2ex_result, cyc);
      end else begin
        e = sb_q.pop_front();
        if (md2ex_result !== e.res || md2ex_wr_regindex !== e.rd || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL result_beat: got res=%h rd=%0d cyc=%0d, required res=%h rd=%0d cyc=%0d",
                   md2ex_result, md2ex_wr_regindex, cyc, e.res, e.rd, e.cyc);
        end
      end
    end
  end

  task automatic drive_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(posedge clk); #1;
    md_op = 1'b1; inst_valid = 1'b1; funct3 = f; opa = a; opb = b; rd_in = rd;
  endtask

  task automatic release_op();
    @(posedge clk); #1;
    md_op = 1'b0; inst_valid = 1'b0;
  endtask

  // Issues one instruction and checks stall/busy/valid every cycle until its beat.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res);
    int lat, t0;
    lat = op_lat(f, a, b);
    drive_op(f, a, b, rd);
    t0 = cyc;
    sb_q.push_back('{exp_res, rd, t0 + lat});
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      n_cmp++;
      if (md2ex_stall !== (k < lat) || md2ex_busy !== (k > 0) || md2ex_valid !== (k == lat)) begin
        n_fail++;
        $display("FAIL %s_handshake: k=%0d stall=%b busy=%b valid=%b, required stall=%b busy=%b valid=%b",
                 name, k, md2ex_stall, md2ex_busy, md2ex_valid, (k < lat), (k > 0), (k == lat));
      end
    end
  endtask

  task automatic check_idle_outputs(input string name, input logic [31:0] exp_res);
    n_cmp++;
    if (md2ex_stall !== 1'b0 || md2ex_valid !== 1'b0 || md2ex_busy !== 1'b0 ||
        md2ex_result !== exp_res || md2ex_wr_regindex !== 5'd0) begin
      n_fail++;
      $display("FAIL %s: stall=%b valid=%b busy=%b res=%h rd=%0d, required 0 0 0 %h 0",
               name, md2ex_stall, md2ex_valid, md2ex_busy, md2ex_result, md2ex_wr_regindex, exp_res);
    end
  endtask

  task automatic test_reset();
    #12;
    check_idle_outputs("reset_held", 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_released", 32'd0);
  endtask

  task automatic test_no_start();
    @(posedge clk); #1;
    md_op = 1'b1; inst_valid = 1'b0; funct3 = 3'd5; opa = 32'd9; opb = 32'd3;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (md2ex_stall !== 1'b0 || md2ex_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL unqualified_start: stall=%b busy=%b, required 0 0", md2ex_stall, md2ex_busy);
    end
    release_op();
  endtask

  task automatic test_mul();
    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB);
    release_op();
  endtask

  task automatic test_mulh();
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000);
    release_op();
    run_op("mulhu", 3'd3, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000);
    release_op();
    run_op("mulhsu", 3'd2, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'hC000_0000);
    release_op();
    run_op("mulh_neg", 3'd1, 32'hFFFF_FFFF, 32'd5, 5'd7, 32'hFFFF_FFFF);
    release_op();
  endtask

  task automatic test_div();
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFD);
    release_op();
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFF);
    release_op();
    run_op("divu_big", 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd10, 32'd1);
    release_op();
    run_op("remu_big", 3'd7, 32'hFFFF_FFFF, 32'h8000_0001, 5'd11, 32'h7FFF_FFFE);
    release_op();
  endtask

  task automatic test_special();
    run_op("divu_zero", 3'd5, 32'h1234_5678, 32'd0, 5'd12, 32'hFFFF_FFFF);
    release_op();
    run_op("remu_zero", 3'd7, 32'h1234_5678, 32'd0, 5'd13, 32'h1234_5678);
    release_op();
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000);
    release_op();
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0);
    release_op();
  endtask

  task automatic test_flush();
    drive_op(3'd5, 32'd1000, 32'd7, 5'd16);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (md2ex_valid !== 1'b0 || md2ex_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_cycle: valid=%b busy=%b, required valid=0 busy=1", md2ex_valid, md2ex_busy);
    end
    @(posedge clk); #1;
    flush = 1'b0; md_op = 1'b0; inst_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (md2ex_stall !== 1'b0 || md2ex_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: stall=%b busy=%b, required 0 0", md2ex_stall, md2ex_busy);
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_mul", 3'd0, 32'd12, 32'd11, 5'd5, 32'd132);
    run_op("b2b_div", 3'd4, 32'd100, 32'hFFFF_FFFD, 5'd6, 32'hFFFF_FFDF);
    release_op();
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      run_op("random", f, a, b, 5'(i + 20), md_model(f, a, b));
      release_op();
    end
  endtask

  task automatic test_reset_mid_calc();
    drive_op(3'd4, 32'd5000, 32'd3, 5'd17);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    md_op = 1'b0; inst_valid = 1'b0;
    #1 rst = 1'b1;
    #1 check_idle_outputs("reset_mid_calc", 32'd0);
    @(negedge clk); rst = 1'b0;
    run_op("after_reset", 3'd5, 32'd5000, 32'd3, 5'd18, 32'd1666);
    release_op();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_no_start();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_mid_calc();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_beats: %0d outstanding, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
